// File: rtl/image_window_gen_pkg.sv
// image_proc_pkg: shared defaults, window width and FSM state encoding for image_window_gen
// Contents: DEFAULT_IMAGE_WIDTH, DEFAULT_PIXEL_W, WINDOW_W, state_t (ST_IDLE, ST_READ)
package image_proc_pkg;
    localparam int DEFAULT_IMAGE_WIDTH = 512;
    localparam int DEFAULT_PIXEL_W     = 8;
    localparam int WINDOW_W            = 9 * DEFAULT_PIXEL_W;
    typedef enum logic {ST_IDLE, ST_READ} state_t;
endpackage

// File: rtl/image_window_gen_if.sv
// image_window_gen_if: pixel stream in, 3x3 window stream out
// Signals: pixel_in_valid/pixel_in (source -> generator), window_out/window_out_valid/overflow (generator -> sink)
// Modports: master = pixel source / window sink, slave = window generator
interface image_window_gen_if
    import image_proc_pkg::*;
#(
    parameter int PIXEL_W = DEFAULT_PIXEL_W
);
    logic                 pixel_in_valid;
    logic [PIXEL_W-1:0]   pixel_in;
    logic [9*PIXEL_W-1:0] window_out;
    logic                 window_out_valid;
    logic                 overflow;
    modport master (output pixel_in_valid, pixel_in, input window_out, window_out_valid, overflow);
    modport slave (input pixel_in_valid, pixel_in, output window_out, window_out_valid, overflow);
endinterface

// File: rtl/image_window_gen_line_buffer.sv
// line_buffer: one image row of storage, single write port, combinational 3-tap read
// Ports: clk; i_we/i_wcol/i_wdata write port; i_rcol read column;
//        o_tap_l/o_tap_c/o_tap_r raw pixels at i_rcol-1, i_rcol, i_rcol+1
//        (edge taps are clamped to a valid address; the caller decides what edges mean)
module line_buffer
    import image_proc_pkg::*;
#(
    parameter int IMAGE_WIDTH = DEFAULT_IMAGE_WIDTH,
    parameter int PIXEL_W     = DEFAULT_PIXEL_W
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(IMAGE_WIDTH)-1:0] i_wcol,
    input  logic [PIXEL_W-1:0]             i_wdata,
    input  logic [$clog2(IMAGE_WIDTH)-1:0] i_rcol,
    output logic [PIXEL_W-1:0]             o_tap_l,
    output logic [PIXEL_W-1:0]             o_tap_c,
    output logic [PIXEL_W-1:0]             o_tap_r
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);

    logic [PIXEL_W-1:0] r_mem [IMAGE_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wcol] <= i_wdata;
    end

    assign o_tap_l = r_mem[(i_rcol == '0) ? i_rcol : i_rcol - CW'(1)];
    assign o_tap_c = r_mem[i_rcol];
    assign o_tap_r = r_mem[(i_rcol == LAST_COL) ? i_rcol : i_rcol + CW'(1)];
endmodule

// File: rtl/image_window_gen.sv
// image_window_gen: raster pixel stream -> registered 3x3 windows over four rotating line buffers
// Ports: clk, rst (sync, active-high); bus (slave modport of image_window_gen_if)
// Build option: define WINDOW_EDGE_REPLICATE_EN to replicate edge columns instead of zero padding
module image_window_gen
    import image_proc_pkg::*;
#(
    parameter int IMAGE_WIDTH = DEFAULT_IMAGE_WIDTH,
    parameter int PIXEL_W     = DEFAULT_PIXEL_W
) (
    input logic               clk,
    input logic               rst,
    image_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int NW = $clog2(4 * IMAGE_WIDTH + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [NW-1:0] FULL     = NW'(4 * IMAGE_WIDTH);
    localparam logic [NW-1:0] ROWS3    = NW'(3 * IMAGE_WIDTH);
`ifdef WINDOW_EDGE_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    state_t               r_state, w_state_nxt;
    logic [NW-1:0]        r_count;
    logic [CW-1:0]        r_wr_col, r_rd_col;
    logic [1:0]           r_wr_buf, r_rd_base;
    logic                 r_overflow, r_win_valid;
    logic [9*PIXEL_W-1:0] r_win, w_win;
    logic                 w_accept, w_read, w_drop;
    logic [1:0]           w_row [3];
    logic [PIXEL_W-1:0]   w_tap [4][3];

    // A full store drops the pixel; nothing is written or advanced while in reset
    assign w_read   = r_state == ST_READ;
    assign w_drop   = bus.pixel_in_valid && !rst && r_count == FULL;
    assign w_accept = bus.pixel_in_valid && !rst && r_count != FULL;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_lb
        line_buffer #(.IMAGE_WIDTH(IMAGE_WIDTH), .PIXEL_W(PIXEL_W)) u_lb (
            .clk     (clk),
            .i_we    (w_accept && r_wr_buf == 2'(g)),
            .i_wcol  (r_wr_col),
            .i_wdata (bus.pixel_in),
            .i_rcol  (r_rd_col),
            .o_tap_l (w_tap[g][0]),
            .o_tap_c (w_tap[g][1]),
            .o_tap_r (w_tap[g][2])
        );
    end

    assign w_state_nxt = (r_state == ST_IDLE) ? ((r_count >= ROWS3) ? ST_READ : ST_IDLE)
                                              : ((r_rd_col == LAST_COL) ? ST_IDLE : ST_READ);

    // Row 0 of the window is the oldest buffer; buffer indices wrap mod 4
    always_comb begin
        for (int r = 0; r < 3; r++) w_row[r] = r_rd_base + 2'(r);
    end

    always_comb begin
        w_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_win[(3*r+c)*PIXEL_W +: PIXEL_W] =
                    ((c == 0 && r_rd_col == '0) || (c == 2 && r_rd_col == LAST_COL))
                    ? (REPLICATE ? w_tap[w_row[r]][1] : '0) : w_tap[w_row[r]][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_wr_col    <= '0;
            r_rd_col    <= '0;
            r_wr_buf    <= '0;
            r_rd_base   <= '0;
            r_overflow  <= 1'b0;
            r_win_valid <= 1'b0;
            r_win       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= r_count + NW'(w_accept) - NW'(w_read);
            r_win_valid <= w_read;
            if (w_drop) r_overflow <= 1'b1;
            if (w_accept) begin
                r_wr_col <= (r_wr_col == LAST_COL) ? '0 : r_wr_col + CW'(1);
                if (r_wr_col == LAST_COL) r_wr_buf <= r_wr_buf + 2'd1;
            end
            if (w_read) begin
                r_win    <= w_win;
                r_rd_col <= (r_rd_col == LAST_COL) ? '0 : r_rd_col + CW'(1);
                if (r_rd_col == LAST_COL) r_rd_base <= r_rd_base + 2'd1;
            end
        end
    end

    assign bus.window_out       = r_win;
    assign bus.window_out_valid = r_win_valid;
    assign bus.overflow         = r_overflow;
endmodule

// File: tb/tb_image_window_gen.sv
// tb_image_window_gen: directed self-checking bench for image_window_gen at IMAGE_WIDTH=4
module tb_image_window_gen;
    import image_proc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [71:0] q_win [$];
    int          q_cyc [$];

    image_window_gen_if #(.PIXEL_W(8)) bus ();

    image_window_gen #(.IMAGE_WIDTH(4), .PIXEL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.window_out_valid === 1'b1) begin
            q_win.push_back(bus.window_out);
            q_cyc.push_back(cyc);
        end
    end

    // Expected window for output column col when the top row starts with pixel value top
    function automatic logic [71:0] exp_win(input int top, input int col);
        logic [71:0] w;
        int cc, v;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                cc = col - 1 + k;
`ifdef WINDOW_EDGE_REPLICATE_EN
                v = top + 4 * r + ((cc < 0) ? 0 : (cc > 3) ? 3 : cc);
`else
                v = (cc < 0 || cc > 3) ? 0 : top + 4 * r + cc;
`endif
                w[(3*r+k)*8 +: 8] = 8'(v);
            end
        end
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int b0, b1, b2, b3, b4, b5, b6, b7, b8);
        return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic send(input int v);
        bus.pixel_in_valid = 1'b1;
        bus.pixel_in = 8'(v);
        @(posedge clk);
        #1;
        bus.pixel_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_win.delete();
        q_cyc.delete();
    endtask

    // Checks the four windows of one output row against exp_win(top, i); t0 = first expected stamp (0 skips timing)
    task automatic check_row(input string name, input int top, input int t0);
        checks++;
        if (q_win.size() !== 4) begin
            failures++;
            $display("FAIL %s_count got %0d windows required 4", name, q_win.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_win.size()) begin
                failures++;
                $display("FAIL %s_col%0d got none required %h", name, i, exp_win(top, i));
            end else if (q_win[i] !== exp_win(top, i)) begin
                failures++;
                $display("FAIL %s_col%0d got %h required %h", name, i, q_win[i], exp_win(top, i));
            end else if (t0 != 0 && q_cyc[i] !== t0 + i) begin
                failures++;
                $display("FAIL %s_time%0d got cycle %0d required %0d", name, i, q_cyc[i], t0 + i);
            end
        end
    endtask

    task automatic test_reset();
        bus.pixel_in_valid = 1'b1;
        bus.pixel_in = 8'hAA;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pixel_in_valid = 1'b0;
        checks++;
        if (bus.window_out !== 72'h0) begin failures++; $display("FAIL reset_window got %h required 0", bus.window_out); end
        checks++;
        if (bus.window_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", bus.window_out_valid); end
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b required 0", bus.overflow); end
        checks++;
        if (dut.r_count !== 5'd0) begin failures++; $display("FAIL reset_count got %0d required 0", dut.r_count); end
        q_win.delete();
        q_cyc.delete();
        for (int p = 1; p <= 11; p++) send(p);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (q_win.size() !== 0) begin failures++; $display("FAIL reset_11px got %0d windows required 0", q_win.size()); end
    endtask

    task automatic test_first_row();
        int t;
        do_reset();
        for (int p = 1; p <= 12; p++) send(p);
        t = cyc;
        repeat (10) @(posedge clk);
        #1;
        check_row("first_row", 1, t + 2);
        checks++;
        if (q_win.size() > 0 && q_win[0] !== pack9(0, 1, 2, 0, 5, 6, 0, 9, 10) && exp_win(1, 0) === pack9(0, 1, 2, 0, 5, 6, 0, 9, 10)) begin
            failures++;
            $display("FAIL first_row_col0_literal got %h required %h", q_win[0], pack9(0, 1, 2, 0, 5, 6, 0, 9, 10));
        end
    endtask

    task automatic test_next_row();
        q_win.delete();
        q_cyc.delete();
        for (int p = 13; p <= 16; p++) send(p);
        repeat (12) @(posedge clk);
        #1;
        check_row("next_row", 5, 0);
        checks++;
        if (q_win.size() < 2 || q_win[1] !== pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin
            failures++;
            $display("FAIL next_row_col1_literal got %h required %h", (q_win.size() > 1) ? q_win[1] : 72'h0, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end
    endtask

    task automatic test_gaps();
        int t;
        do_reset();
        for (int p = 1; p <= 12; p++) begin
            send(p);
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        t = (q_cyc.size() > 0) ? q_cyc[0] : 0;
        check_row("gaps", 1, t);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        for (int p = 1; p <= 12; p++) send(p);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.window_out_valid !== 1'b0) begin failures++; $display("FAIL midread_valid got %b required 0", bus.window_out_valid); end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (q_win.size() !== 2) begin failures++; $display("FAIL midread_count got %0d windows required 2", q_win.size()); end
        q_win.delete();
        q_cyc.delete();
        for (int p = 101; p <= 112; p++) send(p);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (q_win.size() < 1 || q_win[0] !== exp_win(101, 0)) begin
            failures++;
            $display("FAIL midread_fresh_col0 got %h required %h", (q_win.size() > 0) ? q_win[0] : 72'h0, exp_win(101, 0));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        force dut.r_state = ST_IDLE;
        for (int p = 1; p <= 16; p++) send(p);
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_16px got %b required 0", bus.overflow); end
        checks++;
        if (dut.r_count !== 5'd16) begin failures++; $display("FAIL ovf_count16 got %0d required 16", dut.r_count); end
        send(17);
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_17px got %b required 1", bus.overflow); end
        send(18);
        checks++;
        if (dut.r_count !== 5'd16) begin failures++; $display("FAIL ovf_count_hold got %0d required 16", dut.r_count); end
        release dut.r_state;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b required 1", bus.overflow); end
        do_reset();
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got %b required 0", bus.overflow); end
    endtask

    initial begin
        bus.pixel_in_valid = 1'b0;
        bus.pixel_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_row();
        test_next_row();
        test_gaps();
        test_reset_mid_read();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_window_gen.md
IMAGE_WINDOW_GEN -- requirements
Module: image_window_gen

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512: pixels per image row.
REQ-002 Parameter PIXEL_W, default 8: bits per pixel.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pixel_in_valid  input  1  pixel_in carries a valid raster-order pixel this cycle.
REQ-006 pixel_in  input  PIXEL_W  input pixel.
REQ-007 window_out  output  9*PIXEL_W (72)  3x3 window feeding the blur stage.
REQ-008 window_out_valid  output  1  window_out valid this cycle.
REQ-009 overflow  output  1  sticky; an input pixel was dropped.

Function
REQ-010 Storage SHALL be 4 line buffers of IMAGE_WIDTH pixels: one written while three are read.
REQ-011 Writes SHALL fill columns 0..IMAGE_WIDTH-1 of the current write buffer. On column wrap, the write column SHALL return to 0 and the write buffer index SHALL advance mod 4.
REQ-012 A pixel counter (0..4*IMAGE_WIDTH) SHALL track the number of stored, unretired pixels. It SHALL increment on each accepted write and decrement on each READ cycle. A simultaneous write and read SHALL leave it unchanged.
REQ-013 FSM states SHALL be IDLE and READ.
  - IDLE->READ when counter >= 3*IMAGE_WIDTH.
  - READ issues one output column per cycle, 0..IMAGE_WIDTH-1.
  - READ->IDLE after column IMAGE_WIDTH-1; the read buffer base then advances mod 4.
REQ-014 Window for output column c SHALL use columns c-1, c, c+1 of the three read buffers, oldest row on top.
REQ-015 Window packing: byte k = window_out[k*8 +: 8] with k = 3*row + col, where row 0 = top (oldest) and col 0 = left; k=4 is the centre.
REQ-016 window_out and window_out_valid SHALL be registered, one cycle after the READ cycle that issued the column. window_out_valid SHALL be 0 in every other cycle.
REQ-017 No vertical padding: an image of H rows SHALL yield (H-2)*IMAGE_WIDTH windows.
REQ-018 When pixel_in_valid=1 and counter = 4*IMAGE_WIDTH, the pixel SHALL be dropped, no state SHALL advance, and overflow SHALL be set until reset.
REQ-019 Gaps in pixel_in_valid SHALL NOT alter window contents or ordering.
REQ-020 There is no downstream backpressure; READ SHALL never stall.

Reset
REQ-021 On rst=1, at the next edge:
  - FSM SHALL go to IDLE.
  - Counter, write/read column, and buffer indices SHALL go to 0.
  - window_out, window_out_valid and overflow SHALL go to 0.
REQ-022 Line buffer contents SHALL NOT be cleared. A reset during READ SHALL abort the row with no further valid output.
REQ-023 pixel_in_valid SHALL be ignored in a cycle where rst=1.

Configuration
REQ-024 Macro WINDOW_EDGE_REPLICATE_EN selects edge handling:
  - Defined: out-of-range columns (-1, IMAGE_WIDTH) SHALL replicate columns 0 and IMAGE_WIDTH-1 respectively.
  - Undefined: out-of-range columns SHALL read as 0.

Structure
REQ-025 Shared package image_proc_pkg SHALL hold IMAGE_WIDTH and PIXEL_W defaults, WINDOW_W = 9*PIXEL_W, and the FSM state encoding.
REQ-026 Sub-module line_buffer SHALL provide one write port and a combinational 3-tap read at c-1, c, c+1, returning raw taps. The top level SHALL apply edge handling and is instantiated 4 times.

Verification (IMAGE_WIDTH=4; pixels numbered by arrival value 1,2,3,...)
REQ-027 Reset:
  - Hold rst 2 cycles with pixel_in_valid=1 -> all outputs 0 and counter 0.
  - Then 11 pixels -> no window_out_valid.
REQ-028 First row:
  - Stream pixels 1..12 back-to-back, last pixel at cycle t -> window_out_valid high for cycles t+3..t+6 only.
  - Column 0 = bytes k0..k8 [0,1,2,0,5,6,0,9,10] (zero pad), or [1,1,2,5,5,6,9,9,10] with WINDOW_EDGE_REPLICATE_EN.
REQ-029 Next row:
  - Continue with pixels 13..16 -> second row of 4 windows.
  - Column 3 = [7,8,0,11,12,0,15,16,0].
  - Column 1 = [5,6,7,9,10,11,13,14,15].
REQ-030 Gaps: repeat REQ-028 with pixel_in_valid on every other cycle -> identical window values and order.
REQ-031 Reset mid-read:
  - Assert rst during the READ cycle for column 2 -> window_out_valid 0 from the next cycle.
  - Then fresh pixels 101..112 -> column 0 = [0,101,102,0,105,106,0,109,110].
REQ-032 Overflow:
  - Force IMAGE_WIDTH=4 and 16 pixels with reads inhibited by a bench-held reset of the FSM only (white-box), then a 17th pixel -> overflow=1.
  - Counter stays 16; overflow stays 1 until rst.
